muldiv_unit: RTL

Iterative RV32M multiply/divide unit. It consumes the two source operands read from the register file (ports A/B) together with the destination index. It produces a 32-bit result plus a one-cycle write strobe that drives the register file write port (upr_in/in/WrEn). The unit stalls the issuing stage via `busy` while an operation is in flight.

---
 rtl/muldiv_unit.sv | 98 +++++++++
 1 files changed

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide unit.
// It runs 32 shift-add or restoring-divide steps and drives the register-file write port on completion.
module muldiv_unit (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_start,
    input  logic [2:0]  i_funct3,
    input  logic [31:0] i_op_a,
    input  logic [31:0] i_op_b,
    input  logic [4:0]  i_rd,
    output logic        o_busy,
    output logic        o_done,
    output logic [31:0] o_result,
    output logic [4:0]  o_wr_addr,
    output logic        o_wr_en
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CALC = 2'd1;
    localparam logic [1:0] DONE = 2'd2;
    logic [1:0]  r_state;
    logic [5:0]  r_cnt;
    logic [2:0]  r_f3;
    logic [4:0]  r_wr_addr;
    logic [31:0] r_a, r_b, r_result;
    logic [63:0] r_acc;
    logic [32:0] r_rem;
    logic        r_neg;
    logic        w_sa, w_sb, w_na, w_nb, w_dz, w_ovf, w_div_ge;
    logic [31:0] w_mag_a, w_mag_b, w_fast_res, w_q_nx, w_quo, w_rmd, w_res;
    logic [32:0] w_mul_sum, w_rem_nx;
    logic [33:0] w_div_sh, w_div_diff;
    logic [63:0] w_mul_nx, w_prod;
    assign w_sa       = (i_funct3 == 3'b001) || (i_funct3 == 3'b010) || (i_funct3[2] && !i_funct3[0]);
    assign w_sb       = (i_funct3 == 3'b001) || (i_funct3[2] && !i_funct3[0]);
    assign w_na       = w_sa && i_op_a[31];
    assign w_nb       = w_sb && i_op_b[31];
    assign w_mag_a    = w_na ? -i_op_a : i_op_a;
    assign w_mag_b    = w_nb ? -i_op_b : i_op_b;
    assign w_dz       = i_funct3[2] && (i_op_b == 32'd0);
    assign w_ovf      = i_funct3[2] && !i_funct3[0] && (i_op_a == 32'h8000_0000) && (i_op_b == 32'hFFFF_FFFF);
    assign w_fast_res = w_dz ? (i_funct3[1] ? i_op_a : 32'hFFFF_FFFF) : (i_funct3[1] ? 32'd0 : 32'h8000_0000);
    // Multiply: high half accumulates, low half holds the multiplier and shifts out one bit per step
    assign w_mul_sum  = {1'b0, r_acc[63:32]} + (r_acc[0] ? {1'b0, r_a} : 33'd0);
    assign w_mul_nx   = {w_mul_sum, r_acc[31:1]};
    // Divide: low half of the accumulator shifts the dividend out and the quotient in
    assign w_div_sh   = {r_rem, r_acc[31]};
    assign w_div_diff = w_div_sh - {2'b00, r_b};
    assign w_div_ge   = !w_div_diff[33];
    assign w_rem_nx   = w_div_ge ? w_div_diff[32:0] : w_div_sh[32:0];
    assign w_q_nx     = {r_acc[30:0], w_div_ge};
    assign w_prod     = r_neg ? -w_mul_nx : w_mul_nx;
    assign w_quo      = r_neg ? -w_q_nx : w_q_nx;
    assign w_rmd      = r_neg ? -w_rem_nx[31:0] : w_rem_nx[31:0];
    assign w_res      = !r_f3[2] ? ((r_f3[1:0] == 2'b00) ? w_prod[31:0] : w_prod[63:32]) : (r_f3[1] ? w_rmd : w_quo);
    assign o_busy     = r_state != IDLE;
    assign o_done     = r_state == DONE;
    assign o_wr_en    = o_done && (r_wr_addr != 5'd0);
    assign o_result   = r_result;
    assign o_wr_addr  = r_wr_addr;
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_f3      <= '0;
            r_wr_addr <= '0;
            r_a       <= '0;
            r_b       <= '0;
            r_acc     <= '0;
            r_rem     <= '0;
            r_neg     <= 1'b0;
            r_result  <= '0;
        end else if (r_state == IDLE) begin
            if (i_start) begin
                r_f3      <= i_funct3;
                r_wr_addr <= i_rd;
                r_a       <= w_mag_a;
                r_b       <= w_mag_b;
                r_neg     <= (i_funct3[2] && i_funct3[1]) ? w_na : (w_na ^ w_nb);
                r_cnt     <= '0;
                r_rem     <= '0;
                r_acc     <= {32'd0, i_funct3[2] ? w_mag_a : w_mag_b};
                r_state   <= (w_dz || w_ovf) ? DONE : CALC;
                if (w_dz || w_ovf)
                    r_result <= w_fast_res;
            end
        end else if (r_state == CALC) begin
            r_cnt <= r_cnt + 6'd1;
            r_acc <= r_f3[2] ? {r_acc[63:32], w_q_nx} : w_mul_nx;
            r_rem <= w_rem_nx;
            if (r_cnt == 6'd31) begin
                r_result <= w_res;
                r_state  <= DONE;
            end
        end else begin
            r_state <= IDLE;
        end
    end
endmodule
